systolic_result_packer: RTL

Downstream consumer of systolic_array's serial result port. Pops one result element per handshake in row-major order (z00, z01, z10, z11, ...). Packs each matrix row into one wide word and presents it on a ready/valid output with row index and last-row flag. Decouples the array's one-element-per-cycle drain from a row-wide sink such as a writeback buffer or host FIFO.

---
 rtl/systolic_result_packer_if.sv | 34 +++
 rtl/systolic_result_packer.sv | 107 ++++++++++
 2 files changed

// File: rtl/systolic_result_packer_if.sv
// systolic_result_packer_if
//   Bundles the element-side handshake from systolic_array and the row-side
//   handshake to the downstream sink.
//   Element side: valid_i/data_i in, yumi_o out, clear_i in (synchronous abort).
//   Row side:     valid_o/data_o/row_idx_o/last_o out, ready_i in.
//   slave  : the packer itself.
//   master : whoever drives the packer (array + sink, or a testbench).
interface systolic_result_packer_if #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) ();
    localparam int RW = (array_height_p > 1) ? $clog2(array_height_p) : 1;

    logic                               valid_i;
    logic [width_p-1:0]                 data_i;
    logic                               yumi_o;
    logic                               clear_i;
    logic                               valid_o;
    logic                               ready_i;
    logic [array_width_p*width_p-1:0]   data_o;
    logic [RW-1:0]                      row_idx_o;
    logic                               last_o;

    modport slave (
        input  valid_i, data_i, clear_i, ready_i,
        output yumi_o, valid_o, data_o, row_idx_o, last_o
    );

    modport master (
        output valid_i, data_i, clear_i, ready_i,
        input  yumi_o, valid_o, data_o, row_idx_o, last_o
    );
endinterface

// File: rtl/systolic_result_packer.sv
// systolic_result_packer
//   Pops result elements one at a time (row-major) from systolic_array and
//   presents each completed matrix row as one wide word with its row index
//   and a last-row flag.
//   Ports:
//     clk_i      clock, rising edge
//     reset_n_i  asynchronous active-low reset
//     bus        systolic_result_packer_if.slave (element in, row out)
module systolic_result_packer #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    systolic_result_packer_if.slave  bus
);
    localparam int CW = (array_width_p > 1) ? $clog2(array_width_p) : 1;
    localparam int RW = (array_height_p > 1) ? $clog2(array_height_p) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(array_width_p - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(array_height_p - 1);

    typedef enum logic {FILL, SEND} state_e;

    state_e                                   state_q, state_d;
    logic [CW-1:0]                            col_q, col_d;
    logic [RW-1:0]                            row_q, row_d;
    logic [RW-1:0]                            row_idx_q, row_idx_d;
    logic [array_width_p-1:0][width_p-1:0]    buf_q, buf_d;
    logic [array_width_p-1:0][width_p-1:0]    data_q, data_d;
    logic                                     valid_q, valid_d;
    logic                                     accept;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        row_idx_d = row_idx_q;
        buf_d     = buf_q;
        data_d    = data_q;
        valid_d   = valid_q;
        accept    = 1'b0;

        if (bus.clear_i) begin
            // Abort: drop partial row and any pending row, restart at z00.
            state_d = FILL;
            col_d   = '0;
            row_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.valid_i) begin
                        accept       = 1'b1;
                        buf_d[col_q] = bus.data_i;
                        if (col_q == COL_LAST) begin
                            // buf_d already holds the element just accepted.
                            col_d     = '0;
                            data_d    = buf_d;
                            row_idx_d = row_q;
                            valid_d   = 1'b1;
                            state_d   = SEND;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.ready_i) begin
                        valid_d = 1'b0;
                        state_d = FILL;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= FILL;
            col_q     <= '0;
            row_q     <= '0;
            row_idx_q <= '0;
            buf_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            row_idx_q <= row_idx_d;
            buf_q     <= buf_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    // yumi is combinational from valid_i; gate with reset so nothing is
    // consumed while the packer cannot store it.
    assign bus.yumi_o    = accept & reset_n_i;
    assign bus.valid_o   = valid_q;
    assign bus.data_o    = data_q;
    assign bus.row_idx_o = row_idx_q;
    assign bus.last_o    = valid_q & (row_idx_q == ROW_LAST);
endmodule
